stratixv_tsd_sampler: RTL and testbench

STRATIXV_TSD_SAMPLER -- requirements
Module: stratixv_tsd_sampler

---
 rtl/stratixv_tsd_pkg.sv | 15 +
 rtl/stratixv_tsd_avg.sv | 49 ++++
 rtl/stratixv_tsd_sampler.sv | 158 +++++++++++++++
 tb/tb_stratixv_tsd_sampler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stratixv_tsd_pkg.sv
// Shared types and constants for the Stratix V temperature-sensing diode sampler.
package stratixv_tsd_pkg;

    localparam int unsigned TSD_CODE_W   = 8;
    localparam int unsigned CLEAR_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_CONVERT,
        ST_CAPTURE,
        ST_WAIT
    } tsd_state_e;

endpackage

// File: rtl/stratixv_tsd_avg.sv
// Running accumulator over 2^AVG_LOG2 conversion codes; flags the sample that
// completes a block and presents the truncated average alongside it.
module stratixv_tsd_avg
    import stratixv_tsd_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  flush_i,
    input  logic                  add_i,
    input  logic [TSD_CODE_W-1:0] code_i,
    output logic [TSD_CODE_W-1:0] avg_c,
    output logic                  last_c
);

    localparam int unsigned ACC_W    = TSD_CODE_W + AVG_LOG2;
    localparam int unsigned CNT_W    = AVG_LOG2 + 1;
    localparam int unsigned LAST_CNT = (1 << AVG_LOG2) - 1;

    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Sum including the incoming code; a completed block restarts from zero.
    always_comb begin
        sum    = acc_q + ACC_W'(code_i);
        last_c = add_i && (cnt_q == CNT_W'(LAST_CNT));
        avg_c  = TSD_CODE_W'(sum >> AVG_LOG2);
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add_i) begin
            if (last_c) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/stratixv_tsd_sampler.sv
// Sequences the TSD block through clear/convert/capture/wait, averages the
// returned codes and raises an over-temperature alarm with hysteresis.
module stratixv_tsd_sampler
    import stratixv_tsd_pkg::*;
#(
    parameter int unsigned           SAMPLE_INTERVAL = 1000,
    parameter int unsigned           AVG_LOG2        = 2,
    parameter logic [TSD_CODE_W-1:0] HI_THRESH       = 8'd200,
    parameter logic [TSD_CODE_W-1:0] LO_THRESH       = 8'd190,
    parameter int unsigned           TIMEOUT         = 4096
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  enable,
    output logic                  tsd_ce,
    output logic                  tsd_clr,
    input  logic [TSD_CODE_W-1:0] tsdcalo,
    input  logic                  tsdcaldone,
    output logic [TSD_CODE_W-1:0] temp_code,
    output logic                  temp_valid,
    output logic                  alarm,
    output logic                  timeout_err
);

    localparam int unsigned CNT_MAX = (SAMPLE_INTERVAL > TIMEOUT) ? SAMPLE_INTERVAL : TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    tsd_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TSD_CODE_W-1:0] code_q, code_d;
    logic [TSD_CODE_W-1:0] temp_code_q, temp_code_d;
    logic                  temp_valid_q, temp_valid_d;
    logic                  alarm_q, alarm_d;
    logic                  tmo_q, tmo_d;
    logic                  tsd_ce_q, tsd_ce_d;
    logic                  tsd_clr_q, tsd_clr_d;
    logic                  avg_add, avg_flush, avg_last;
    logic [TSD_CODE_W-1:0] avg_val;

    assign avg_add   = (state_q == ST_CAPTURE) && enable;
    assign avg_flush = clr || !enable;

    stratixv_tsd_avg #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk     (clk),
        .flush_i (avg_flush),
        .add_i   (avg_add),
        .code_i  (code_q),
        .avg_c   (avg_val),
        .last_c  (avg_last)
    );

    // Next state; one shared phase counter times CLEAR, CONVERT and WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (cnt_q == CNT_W'(CLEAR_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_CONVERT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CONVERT: begin
                if (tsdcaldone) begin
                    code_d  = tsdcalo;
                    cnt_d   = '0;
                    state_d = ST_CAPTURE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(SAMPLE_INTERVAL - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        if (!enable) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
        end
    end

    // Diode controls follow the next state so they line up with state_q.
    always_comb begin
        tsd_ce_d     = (state_d == ST_CLEAR) || (state_d == ST_CONVERT);
        tsd_clr_d    = (state_d == ST_CLEAR);
        temp_code_d  = temp_code_q;
        temp_valid_d = 1'b0;
        alarm_d      = alarm_q;
        if (avg_last) begin
            temp_code_d  = avg_val;
            temp_valid_d = 1'b1;
            if (avg_val >= HI_THRESH) begin
                alarm_d = 1'b1;
            end else if (avg_val <= LO_THRESH) begin
                alarm_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            code_q       <= '0;
            temp_code_q  <= '0;
            temp_valid_q <= 1'b0;
            alarm_q      <= 1'b0;
            tmo_q        <= 1'b0;
            tsd_ce_q     <= 1'b0;
            tsd_clr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            temp_code_q  <= temp_code_d;
            temp_valid_q <= temp_valid_d;
            alarm_q      <= alarm_d;
            tmo_q        <= tmo_d;
            tsd_ce_q     <= tsd_ce_d;
            tsd_clr_q    <= tsd_clr_d;
        end
    end

    assign tsd_ce      = tsd_ce_q;
    assign tsd_clr     = tsd_clr_q;
    assign temp_code   = temp_code_q;
    assign temp_valid  = temp_valid_q;
    assign alarm       = alarm_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_stratixv_tsd_sampler.sv
// Scoreboard bench: a diode model answers conversions, a reference average
// predicts each temp_valid result and a negedge monitor compares them.
module tb_stratixv_tsd_sampler;

    localparam int unsigned SAMPLE_INTERVAL = 4;
    localparam int unsigned AVG_LOG2        = 2;
    localparam int unsigned TIMEOUT         = 16;
    localparam logic [7:0]  HI              = 8'd200;
    localparam logic [7:0]  LO              = 8'd190;
    localparam int unsigned NSAMP           = 1 << AVG_LOG2;

    logic       clk = 1'b0;
    logic       clr, enable, tsdcaldone;
    logic [7:0] tsdcalo;
    logic       tsd_ce, tsd_clr, temp_valid, alarm, timeout_err;
    logic [7:0] temp_code;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [7:0] code;
        logic       alarm;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned m_sum = 0;
    int unsigned m_n   = 0;
    logic        m_alarm = 1'b0;

    always #5 clk = ~clk;

    stratixv_tsd_sampler #(
        .SAMPLE_INTERVAL (SAMPLE_INTERVAL),
        .AVG_LOG2        (AVG_LOG2),
        .HI_THRESH       (HI),
        .LO_THRESH       (LO),
        .TIMEOUT         (TIMEOUT)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .enable      (enable),
        .tsd_ce      (tsd_ce),
        .tsd_clr     (tsd_clr),
        .tsdcalo     (tsdcalo),
        .tsdcaldone  (tsdcaldone),
        .temp_code   (temp_code),
        .temp_valid  (temp_valid),
        .alarm       (alarm),
        .timeout_err (timeout_err)
    );

    // Reference model: average blocks of NSAMP codes, hysteresis alarm.
    function automatic void model_sample(input logic [7:0] c);
        logic [7:0] avg;
        m_sum += c;
        m_n++;
        if (m_n == NSAMP) begin
            avg = 8'(m_sum >> AVG_LOG2);
            if (avg >= HI) m_alarm = 1'b1;
            else if (avg <= LO) m_alarm = 1'b0;
            exp_q.push_back('{code: avg, alarm: m_alarm});
            m_sum = 0;
            m_n   = 0;
        end
    endfunction

    function automatic void model_flush();
        m_sum = 0;
        m_n   = 0;
    endfunction

    always @(negedge clk) begin
        if (temp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: temp_code=%0d but no result expected", temp_code);
            end else begin
                mon_e = exp_q.pop_front();
                n_checks++;
                if (temp_code !== mon_e.code)
                    $display("FAIL sb_temp_code: got %0d want %0d", temp_code, mon_e.code);
                else n_pass++;
                n_checks++;
                if (alarm !== mon_e.alarm)
                    $display("FAIL sb_alarm: got %0b want %0b (code %0d)", alarm, mon_e.alarm, mon_e.code);
                else n_pass++;
            end
        end
    end

    // Wait for CONVERT, return the code after a short random latency.
    task automatic do_sample(input logic [7:0] code);
        bit seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (tsd_ce && !tsd_clr) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL sample_wait: no CONVERT within 100 cycles for code %0d", code);
            return;
        end
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
        end
        tsdcalo    = code;
        tsdcaldone = 1'b1;
        @(posedge clk); #1;
        tsdcaldone = 1'b0;
        model_sample(code);
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(posedge clk); #2;
        end
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drain: %0d results still pending, want 0", name, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        clr = 1'b1; enable = 1'b0; tsdcaldone = 1'b0; tsdcalo = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (tsd_ce !== 1'b0) $display("FAIL reset_tsd_ce: got %0b want 0", tsd_ce); else n_pass++;
        n_checks++; if (tsd_clr !== 1'b0) $display("FAIL reset_tsd_clr: got %0b want 0", tsd_clr); else n_pass++;
        n_checks++; if (temp_code !== 8'd0) $display("FAIL reset_temp_code: got %0d want 0", temp_code); else n_pass++;
        n_checks++; if (temp_valid !== 1'b0) $display("FAIL reset_temp_valid: got %0b want 0", temp_valid); else n_pass++;
        n_checks++; if (alarm !== 1'b0) $display("FAIL reset_alarm: got %0b want 0", alarm); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %0b want 0", timeout_err); else n_pass++;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (tsd_ce !== 1'b0) $display("FAIL idle_tsd_ce: got %0b want 0", tsd_ce); else n_pass++;
    endtask

    task automatic test_average();
        enable = 1'b1;
        do_sample(8'd100); do_sample(8'd101); do_sample(8'd102); do_sample(8'd103);
        wait_drain("average");
        @(negedge clk);
        n_checks++; if (temp_code !== 8'd101) $display("FAIL average_hold: got %0d want 101", temp_code); else n_pass++;
        n_checks++; if (temp_valid !== 1'b0) $display("FAIL average_pulse: got %0b want 0", temp_valid); else n_pass++;
    endtask

    // Done held high across CLEAR: capture only in the first CONVERT cycle.
    task automatic test_stale_done();
        int len = 0;
        tsdcalo = 8'd205; tsdcaldone = 1'b1;
        for (int k = 0; k < 20 && tsd_clr !== 1'b1; k++) @(negedge clk);
        while (tsd_clr === 1'b1 && len < 10) begin
            len++;
            @(negedge clk);
        end
        n_checks++; if (len != 2) $display("FAIL stale_clr_len: got %0d want 2", len); else n_pass++;
        n_checks++; if (tsd_ce !== 1'b1) $display("FAIL stale_convert_ce: got %0b want 1", tsd_ce); else n_pass++;
        @(negedge clk);
        n_checks++; if (tsd_ce !== 1'b0) $display("FAIL stale_capture_ce: got %0b want 0", tsd_ce); else n_pass++;
        @(posedge clk); #1;
        tsdcaldone = 1'b0;
        model_sample(8'd205);
        do_sample(8'd205); do_sample(8'd205); do_sample(8'd205);
        wait_drain("stale");
    endtask

    task automatic test_alarm_hysteresis();
        n_checks++; if (alarm !== 1'b1) $display("FAIL alarm_set: got %0b want 1", alarm); else n_pass++;
        for (int i = 0; i < 4; i++) do_sample(8'd195);
        wait_drain("alarm_hold");
        n_checks++; if (alarm !== 1'b1) $display("FAIL alarm_hold: got %0b want 1", alarm); else n_pass++;
        for (int i = 0; i < 4; i++) do_sample(8'd189);
        wait_drain("alarm_clear");
        n_checks++; if (alarm !== 1'b0) $display("FAIL alarm_clear: got %0b want 0", alarm); else n_pass++;
    endtask

    task automatic test_timeout();
        int conv = 0;
        do_sample(8'd40); do_sample(8'd44);
        for (int k = 0; k < 200 && timeout_err !== 1'b1; k++) begin
            @(negedge clk);
            if (timeout_err !== 1'b1 && tsd_ce && !tsd_clr) conv++;
        end
        n_checks++; if (timeout_err !== 1'b1) $display("FAIL timeout_flag: got %0b want 1", timeout_err); else n_pass++;
        n_checks++; if (conv != TIMEOUT) $display("FAIL timeout_cycles: got %0d want %0d", conv, TIMEOUT); else n_pass++;
        n_checks++; if (tsd_ce !== 1'b0) $display("FAIL timeout_wait_ce: got %0b want 0", tsd_ce); else n_pass++;
        do_sample(8'd48); do_sample(8'd52);
        wait_drain("timeout");
        n_checks++; if (temp_code !== 8'd46) $display("FAIL timeout_acc_kept: got %0d want 46", temp_code); else n_pass++;
    endtask

    task automatic test_enable_drop();
        do_sample(8'd10); do_sample(8'd20);
        repeat (2) @(posedge clk);
        #1;
        enable = 1'b0;
        model_flush();
        repeat (3) @(negedge clk);
        n_checks++; if (tsd_ce !== 1'b0) $display("FAIL drop_tsd_ce: got %0b want 0", tsd_ce); else n_pass++;
        n_checks++; if (temp_code !== 8'd46) $display("FAIL drop_temp_hold: got %0d want 46", temp_code); else n_pass++;
        n_checks++; if (timeout_err !== 1'b1) $display("FAIL drop_timeout_sticky: got %0b want 1", timeout_err); else n_pass++;
        @(posedge clk); #1;
        enable = 1'b1;
        do_sample(8'd60); do_sample(8'd64); do_sample(8'd68); do_sample(8'd72);
        wait_drain("enable_drop");
        n_checks++; if (temp_code !== 8'd66) $display("FAIL drop_fresh_avg: got %0d want 66", temp_code); else n_pass++;
    endtask

    task automatic test_clr_mid();
        do_sample(8'd200);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (tsd_ce && !tsd_clr) break;
        end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_flush();
        m_alarm = 1'b0;
        @(negedge clk);
        n_checks++; if (tsd_ce !== 1'b0) $display("FAIL clr_tsd_ce: got %0b want 0", tsd_ce); else n_pass++;
        n_checks++; if (tsd_clr !== 1'b0) $display("FAIL clr_tsd_clr: got %0b want 0", tsd_clr); else n_pass++;
        n_checks++; if (temp_code !== 8'd0) $display("FAIL clr_temp_code: got %0d want 0", temp_code); else n_pass++;
        n_checks++; if (temp_valid !== 1'b0) $display("FAIL clr_temp_valid: got %0b want 0", temp_valid); else n_pass++;
        n_checks++; if (alarm !== 1'b0) $display("FAIL clr_alarm: got %0b want 0", alarm); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL clr_timeout_err: got %0b want 0", timeout_err); else n_pass++;
        do_sample(8'd80); do_sample(8'd80); do_sample(8'd80); do_sample(8'd84);
        wait_drain("clr_mid");
        n_checks++; if (temp_code !== 8'd81) $display("FAIL clr_partial_discard: got %0d want 81", temp_code); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_average();
        test_stale_done();
        test_alarm_hysteresis();
        test_timeout();
        test_enable_drop();
        test_clr_mid();
        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
